mips_cpu_bus: RTL and testbench

//  Multicycle MIPS-I subset CPU core with a single Avalon-style memory bus shared by instruction and data.

---
 rtl/mips_cpu_bus.sv | 223 ++++++++++++++++++++++
 tb/tb_mips_cpu_bus.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_bus.sv
// Multicycle MIPS-I subset core on one shared Avalon-style bus: FETCH -> EXEC (-> MEM for LW/SW).
// Bus strobes derive from state; load/store addresses come straight from the instruction on readdata.
module mips_cpu_bus #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ = 6'h07;
    localparam logic [5:0] OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D, OP_XORI   = 6'h0E, OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23, OP_SW     = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03, F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR   = 6'h08, F_JALR = 6'h09;
    localparam logic [5:0] F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND  = 6'h24, F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26, F_NOR  = 6'h27, F_SLT  = 6'h2A, F_SLTU = 6'h2B;

    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] branch_target;
    logic        branch_pending;
    logic [31:0] regs [32];
    logic [31:0] ir;
    logic        ir_held;
    logic [4:0]  mem_rt;
    logic        mem_load;

    logic [31:0] instr;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] simm, zimm, rs_val, rt_val;
    logic [31:0] pc_plus4, pc_plus8, seq_pc, mem_addr;

    logic        wb_en, taken, is_load, is_store;
    logic [4:0]  wb_idx;
    logic [31:0] wb_val, target;

    // A stalled load/store keeps its own copy so the bus address cannot drift if readdata changes.
    assign instr    = ir_held ? ir : readdata;
    assign op       = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign imm      = instr[15:0];
    assign simm     = {{16{imm[15]}}, imm};
    assign zimm     = {16'd0, imm};
    assign rs_val   = regs[rs];
    assign rt_val   = regs[rt];
    assign pc_plus4 = pc + 32'd4;
    assign pc_plus8 = pc + 32'd8;
    assign seq_pc   = branch_pending ? branch_target : pc_plus4;
    assign mem_addr = rs_val + simm;

    always_comb begin
        wb_en    = 1'b0;
        wb_idx   = rd;
        wb_val   = '0;
        taken    = 1'b0;
        target   = pc_plus4 + {simm[29:0], 2'b00};
        is_load  = 1'b0;
        is_store = 1'b0;
        case (op)
            OP_SPECIAL: begin
                wb_en = 1'b1;
                case (funct)
                    F_SLL:  wb_val = rt_val << shamt;
                    F_SRL:  wb_val = rt_val >> shamt;
                    F_SRA:  wb_val = $signed(rt_val) >>> shamt;
                    F_SLLV: wb_val = rt_val << rs_val[4:0];
                    F_SRLV: wb_val = rt_val >> rs_val[4:0];
                    F_SRAV: wb_val = $signed(rt_val) >>> rs_val[4:0];
                    F_ADDU: wb_val = rs_val + rt_val;
                    F_SUBU: wb_val = rs_val - rt_val;
                    F_AND:  wb_val = rs_val & rt_val;
                    F_OR:   wb_val = rs_val | rt_val;
                    F_XOR:  wb_val = rs_val ^ rt_val;
                    F_NOR:  wb_val = ~(rs_val | rt_val);
                    F_SLT:  wb_val = {31'd0, $signed(rs_val) < $signed(rt_val)};
                    F_SLTU: wb_val = {31'd0, rs_val < rt_val};
                    F_JR: begin
                        wb_en  = 1'b0;
                        taken  = 1'b1;
                        target = rs_val;
                    end
                    F_JALR: begin
                        taken  = 1'b1;
                        target = rs_val;
                        wb_val = pc_plus8;
                    end
                    default: wb_en = 1'b0;
                endcase
            end
            OP_REGIMM: begin
                if (rt == 5'd0)
                    taken = rs_val[31];
                else if (rt == 5'd1)
                    taken = !rs_val[31];
            end
            OP_J, OP_JAL: begin
                taken  = 1'b1;
                target = {pc[31:28], instr[25:0], 2'b00};
                wb_en  = (op == OP_JAL);
                wb_idx = 5'd31;
                wb_val = pc_plus8;
            end
            OP_BEQ:  taken = (rs_val == rt_val);
            OP_BNE:  taken = (rs_val != rt_val);
            OP_BLEZ: taken = rs_val[31] || (rs_val == 32'd0);
            OP_BGTZ: taken = !rs_val[31] && (rs_val != 32'd0);
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                wb_en  = 1'b1;
                wb_idx = rt;
                case (op)
                    OP_ADDIU: wb_val = rs_val + simm;
                    OP_SLTI:  wb_val = {31'd0, $signed(rs_val) < $signed(simm)};
                    OP_SLTIU: wb_val = {31'd0, rs_val < simm};
                    OP_ANDI:  wb_val = rs_val & zimm;
                    OP_ORI:   wb_val = rs_val | zimm;
                    OP_XORI:  wb_val = rs_val ^ zimm;
                    default:  wb_val = {imm, 16'd0};
                endcase
            end
            OP_LW:   is_load  = 1'b1;
            OP_SW:   is_store = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= FETCH;
            pc             <= RESET_VECTOR;
            branch_pending <= 1'b0;
            branch_target  <= '0;
            ir             <= '0;
            ir_held        <= 1'b0;
            mem_rt         <= '0;
            mem_load       <= 1'b0;
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (!waitrequest)
                        state <= EXEC;
                end
                EXEC: begin
                    if (is_load || is_store) begin
                        if (waitrequest) begin
                            ir      <= instr;
                            ir_held <= 1'b1;
                        end else begin
                            ir_held  <= 1'b0;
                            mem_rt   <= rt;
                            mem_load <= is_load;
                            state    <= MEM;
                        end
                    end else begin
                        if (wb_en && wb_idx != 5'd0)
                            regs[wb_idx] <= wb_val;
                        ir_held        <= 1'b0;
                        pc             <= seq_pc;
                        branch_pending <= taken;
                        branch_target  <= target;
                        state          <= (seq_pc == 32'd0) ? HALT : FETCH;
                    end
                end
                MEM: begin
                    if (mem_load && mem_rt != 5'd0)
                        regs[mem_rt] <= readdata;
                    pc             <= seq_pc;
                    branch_pending <= 1'b0;
                    state          <= (seq_pc == 32'd0) ? HALT : FETCH;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        address   = pc;
        read      = 1'b0;
        write     = 1'b0;
        writedata = rt_val;
        case (state)
            FETCH: read = 1'b1;
            EXEC: begin
                if (is_load || is_store) begin
                    address = mem_addr;
                    read    = is_load;
                    write   = is_store;
                end
            end
            default: ;
        endcase
        if (reset) begin
            read  = 1'b0;
            write = 1'b0;
        end
    end

    assign active      = (state != HALT);
    assign register_v0 = regs[2];
    assign byteenable  = 4'b1111;

endmodule

// File: tb/tb_mips_cpu_bus.sv
// Runs a directed program and randomized programs; every bus access is compared in order against
// an instruction-level reference model, with a memory slave that inserts waitrequest stalls.
module tb_mips_cpu_bus;
    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        waitrequest = 1'b0;
    logic [31:0] readdata = '0;
    logic        active, write, read;
    logic [31:0] register_v0, address, writedata;
    logic [3:0]  byteenable;

    always #5 clk = ~clk;

    mips_cpu_bus dut (
        .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
        .address(address), .write(write), .read(read), .waitrequest(waitrequest),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
    );

    typedef struct packed {
        logic [1:0]  rw;      // {read, write}
        logic        fetch;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] v0;
    } acc_t;

    acc_t        expq[$];
    logic [31:0] rom [128];
    logic [31:0] dm_iss [64];
    logic [31:0] dm_bus [64];
    logic [31:0] iss_v0;
    int          vectors = 0;
    int          miscompares = 0;

    logic [5:0] fns  [14] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                              6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    logic [5:0] iops [7]  = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    logic [5:0] bops [5]  = '{6'h01, 6'h04, 6'h05, 6'h06, 6'h07};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] s, t, d, sh, input logic [5:0] fn);
        return {6'd0, s, t, d, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] o, input logic [4:0] s, t, input logic [15:0] im);
        return {o, s, t, im};
    endfunction

    function automatic logic [4:0] pick_reg();
        int v = $urandom_range(0, 8);
        return (v == 8) ? 5'd31 : 5'(v);
    endfunction

    // Instruction-level reference: one loop iteration per instruction, delay slot via pending target.
    task automatic iss_run();
        logic [31:0] r [32];
        logic [31:0] pc, bt, nxt, ins, a, b, se, ze, wv, tgt, ea;
        logic signed [31:0] sa, sb, sse;
        logic [4:0]  wi, sh;
        logic        bp, tk;
        for (int i = 0; i < 32; i++) r[i] = '0;
        pc = RV; bp = 1'b0; bt = '0;
        expq.delete();
        for (int step = 0; step < 3000; step++) begin
            if (((pc - RV) >> 2) >= 128) begin
                chk("iss_pc_range", pc, RV);
                break;
            end
            ins = rom[(pc - RV) >> 2];
            expq.push_back('{2'b10, 1'b1, pc, 32'd0, r[2]});
            a = r[ins[25:21]]; b = r[ins[20:16]];
            sa = a; sb = b;
            se = {{16{ins[15]}}, ins[15:0]}; ze = {16'd0, ins[15:0]}; sse = se;
            sh = ins[10:6];
            wi = 5'd0; wv = '0; tk = 1'b0; tgt = pc + 32'd4 + (se << 2);
            case (ins[31:26])
                6'h00: begin
                    wi = ins[15:11];
                    case (ins[5:0])
                        6'h00: wv = b << sh;
                        6'h02: wv = b >> sh;
                        6'h03: wv = sb >>> sh;
                        6'h04: wv = b << a[4:0];
                        6'h06: wv = b >> a[4:0];
                        6'h07: wv = sb >>> a[4:0];
                        6'h08: begin wi = 0; tk = 1; tgt = a; end
                        6'h09: begin tk = 1; tgt = a; wv = pc + 32'd8; end
                        6'h21: wv = a + b;
                        6'h23: wv = a - b;
                        6'h24: wv = a & b;
                        6'h25: wv = a | b;
                        6'h26: wv = a ^ b;
                        6'h27: wv = ~(a | b);
                        6'h2A: wv = (sa < sb) ? 32'd1 : 32'd0;
                        6'h2B: wv = (a < b) ? 32'd1 : 32'd0;
                        default: wi = 0;
                    endcase
                end
                6'h01: tk = (ins[20:16] == 0) ? (sa < 0) : (ins[20:16] == 1) ? (sa >= 0) : 1'b0;
                6'h02: begin tk = 1; tgt = {pc[31:28], ins[25:0], 2'b00}; end
                6'h03: begin tk = 1; tgt = {pc[31:28], ins[25:0], 2'b00}; wi = 31; wv = pc + 32'd8; end
                6'h04: tk = (a == b);
                6'h05: tk = (a != b);
                6'h06: tk = (sa <= 0);
                6'h07: tk = (sa > 0);
                6'h09: begin wi = ins[20:16]; wv = a + se; end
                6'h0A: begin wi = ins[20:16]; wv = (sa < sse) ? 32'd1 : 32'd0; end
                6'h0B: begin wi = ins[20:16]; wv = (a < se) ? 32'd1 : 32'd0; end
                6'h0C: begin wi = ins[20:16]; wv = a & ze; end
                6'h0D: begin wi = ins[20:16]; wv = a | ze; end
                6'h0E: begin wi = ins[20:16]; wv = a ^ ze; end
                6'h0F: begin wi = ins[20:16]; wv = ze << 16; end
                6'h23: begin
                    ea = a + se;
                    wi = ins[20:16]; wv = dm_iss[ea[7:2]];
                    expq.push_back('{2'b10, 1'b0, ea, 32'd0, 32'd0});
                end
                6'h2B: begin
                    ea = a + se;
                    dm_iss[ea[7:2]] = b;
                    expq.push_back('{2'b01, 1'b0, ea, b, 32'd0});
                end
                default: ;
            endcase
            if (wi != 0) r[wi] = wv;
            nxt = bp ? bt : pc + 32'd4;
            bp = tk; bt = tgt; pc = nxt;
            if (pc == 32'd0) break;
        end
        iss_v0 = r[2];
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a[31:28] == 4'hB) return rom[7'((a - RV) >> 2)];
        return dm_bus[a[7:2]];
    endfunction

    // Reset, then act as bus slave until halt; wmode 0 stalls the first fetch 3 cycles, 1 is random.
    task automatic run_prog(input int wmode);
        acc_t        e;
        logic        pend, stalled;
        logic [31:0] pend_addr, prev_addr;
        logic [1:0]  prev_rw;
        int          first_wait;
        pend = 0; stalled = 0; pend_addr = '0; prev_addr = '0; prev_rw = '0;
        first_wait = (wmode == 0) ? 3 : 0;
        reset = 1'b1; waitrequest = 1'b0; readdata = '0;
        @(negedge clk);
        chk("rst_read", {31'd0, read}, 32'd0);
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_v0", register_v0, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rel_active", {31'd0, active}, 32'd1);
        chk("rel_addr", address, RV);
        chk("rel_read", {31'd0, read}, 32'd1);
        chk("rel_write", {31'd0, write}, 32'd0);
        chk("rel_be", {28'd0, byteenable}, 32'hF);
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (pend) begin
                readdata = mem_rd(pend_addr);
                pend = 0;
            end
            #1;
            if (!active) break;
            if (stalled) begin
                chk("hold_addr", address, prev_addr);
                chk("hold_rw", {30'd0, read, write}, {30'd0, prev_rw});
            end
            if (read || write) begin
                if (first_wait > 0) begin
                    waitrequest = 1'b1;
                    first_wait--;
                end else begin
                    waitrequest = (wmode == 1) && ($urandom_range(0, 2) == 0);
                end
                if (!waitrequest) begin
                    if (expq.size() == 0) begin
                        chk("extra_access", address, 32'hFFFFFFFF);
                        break;
                    end
                    e = expq.pop_front();
                    chk("acc_rw", {30'd0, read, write}, {30'd0, e.rw});
                    chk("acc_addr", address, e.addr);
                    chk("acc_be", {28'd0, byteenable}, 32'hF);
                    if (write) chk("acc_wdata", writedata, e.data);
                    if (e.fetch) chk("v0_at_fetch", register_v0, e.v0);
                    if (read) begin
                        pend = 1; pend_addr = address;
                    end
                    if (write) dm_bus[address[7:2]] = writedata;
                end
                stalled = waitrequest; prev_addr = address; prev_rw = {read, write};
            end else begin
                waitrequest = 1'b0;
                stalled = 0;
            end
            @(negedge clk);
        end
        waitrequest = 1'b0;
        chk("halted", {31'd0, active}, 32'd0);
        chk("halt_rw", {30'd0, read, write}, 32'd0);
        chk("exp_left", expq.size(), 32'd0);
        chk("final_v0", register_v0, iss_v0);
        repeat (3) @(negedge clk);
        chk("stay_halted", {31'd0, active}, 32'd0);
    endtask

    task automatic gen_random();
        int n, body_end, k, o;
        logic [4:0]  d, s, t;
        logic [31:0] ta;
        bit          last_br;
        for (int i = 0; i < 128; i++) rom[i] = '0;
        for (int i = 0; i < 64; i++) begin
            dm_iss[i] = $urandom;
            dm_bus[i] = dm_iss[i];
        end
        n = 0;
        for (int r = 1; r < 8; r++) begin
            rom[n++] = itype(6'h0F, 5'd0, 5'(r), 16'($urandom));
            rom[n++] = itype(6'h0D, 5'(r), 5'(r), 16'($urandom));
        end
        body_end = n + 40;
        last_br = 0;
        while (n < body_end) begin
            k = $urandom_range(0, 9);
            d = pick_reg(); s = pick_reg(); t = pick_reg();
            if (k >= 8 && (last_br || n + 4 >= body_end)) k = 0;
            o = $urandom_range(1, 3);
            ta = RV + 32'((n + 1 + o) * 4);
            case (k)
                0, 1, 2, 3: rom[n] = rtype(s, t, d, 5'($urandom), fns[$urandom_range(0, 13)]);
                4, 5:       rom[n] = itype(iops[$urandom_range(0, 6)], s, t, 16'($urandom));
                6:          rom[n] = itype(6'h23, 5'd0, t, 16'($urandom_range(0, 255)));
                7:          rom[n] = itype(6'h2B, 5'd0, t, 16'($urandom_range(0, 63) * 4));
                8: begin
                    rom[n] = itype(bops[$urandom_range(0, 4)], s, t, 16'(o));
                    if (rom[n][31:26] == 6'h01) rom[n][20:16] = 5'($urandom_range(0, 1));
                end
                default:    rom[n] = {6'h03, ta[27:2]};
            endcase
            last_br = (k >= 8);
            n++;
        end
        for (int r = 1; r < 32; r++)
            rom[n++] = itype(6'h2B, 5'd0, 5'(r), 16'(r * 4));
        rom[n++] = 32'h00000008;
        rom[n]   = 32'h24430000;
    endtask

    initial begin
        // Directed: unaligned LW, wraparound ADDIU, SW, JALR link, JR $0 halt through delay slot.
        for (int i = 0; i < 128; i++) rom[i] = '0;
        for (int i = 0; i < 64; i++) begin
            dm_iss[i] = '0;
            dm_bus[i] = '0;
        end
        dm_iss[0] = 32'd192; dm_bus[0] = 32'd192;
        rom[0]  = 32'h8C020001;
        rom[1]  = 32'h3C02FFFF;
        rom[2]  = 32'h3442FFFE;
        rom[3]  = 32'h24420005;
        rom[4]  = 32'hAC020010;
        rom[5]  = 32'h3C06BFC0;
        rom[6]  = 32'h34C60028;
        rom[7]  = 32'h00C02009;
        rom[8]  = 32'h24420001;
        rom[9]  = 32'h24420064;
        rom[10] = 32'hAC040014;
        rom[11] = 32'h00000008;
        rom[12] = 32'h24430000;
        iss_run();
        chk("dir_model_v0", iss_v0, 32'd4);
        run_prog(0);
        chk("dir_v0", register_v0, 32'd4);
        chk("dir_sw_wrap", dm_bus[4], 32'd3);
        chk("dir_sw_link", dm_bus[5], 32'hBFC00024);

        for (int t = 0; t < 4; t++) begin
            gen_random();
            iss_run();
            run_prog(1);
        end

        // Asynchronous reset away from any clock edge must clear state immediately.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_active", {31'd0, active}, 32'd1);
        chk("async_v0", register_v0, 32'd0);
        chk("async_rw", {30'd0, read, write}, 32'd0);
        chk("async_addr", address, RV);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
